// File: rtl/controlador_necessidades_pkg.sv
// Shared definitions for the needs-update engine: estado codes (shared with the
// state controller), need width and the saturating add/sub helper.
package controlador_necessidades_pkg;

   localparam int unsigned NeedW = 8;

   // estado codes driven by the state controller
   localparam logic [4:0] EstIntro     = 5'b00000;
   localparam logic [4:0] EstIdle      = 5'b00001;
   localparam logic [4:0] EstDormindo  = 5'b00010;
   localparam logic [4:0] EstComendo   = 5'b00100;
   localparam logic [4:0] EstDandoAula = 5'b01000;
   localparam logic [4:0] EstMorto     = 5'b10000;

   localparam logic [NeedW:0] NeedMax = {1'b0, {NeedW{1'b1}}};

   // 9-bit add or subtract that clamps to [0, 255] instead of wrapping
   function automatic logic [NeedW-1:0] sat_update(input logic [NeedW-1:0] val,
                                                   input logic [NeedW:0]   delta,
                                                   input logic             sub);
      logic [NeedW:0] ext;
      logic [NeedW:0] res;
      ext = {1'b0, val};
      if (sub) begin
         if (delta > ext) res = '0;
         else             res = ext - delta;
      end else begin
         res = ext + delta;
         if (res > NeedMax) res = NeedMax;
      end
      return res[NeedW-1:0];
   endfunction

endpackage

// File: rtl/divisor_tick.sv
// Free-running TICK_W-bit prescaler; tick is high for the one cycle in which the
// counter is all-ones, giving one update every 2^TICK_W clocks.
module divisor_tick #(
   parameter int unsigned TICK_W = 22
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   logic [TICK_W-1:0] cnt_q;

   // Prescaler counter, wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_q + {{(TICK_W-1){1'b0}}, 1'b1};
   end

   assign tick = &cnt_q;

endmodule

// File: rtl/controlador_necessidades.sv
// Needs-update engine: on each prescaled tick, raises the need served by the
// current activity and decays the others, with saturation at 0 and 255.
// Optional feature macro: NECESSIDADES_MORTE_EN enables the sticky death flag
// `morto` and freezes all needs once it is set.
module controlador_necessidades
   import controlador_necessidades_pkg::*;
#(
   parameter int unsigned     TICK_W      = 22,
   parameter logic [NeedW-1:0] VAL_INICIAL = 8'd128,
   parameter logic [NeedW-1:0] INC         = 8'd8,
   parameter logic [NeedW-1:0] DEC         = 8'd1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       estado,
   output logic [NeedW-1:0] fome,
   output logic [NeedW-1:0] felicidade,
   output logic [NeedW-1:0] sono,
   output logic             morto,
   output logic             tick
);

   localparam logic [NeedW:0] IncX  = {1'b0, INC};
   localparam logic [NeedW:0] DecX  = {1'b0, DEC};
   localparam logic [NeedW:0] Dec2X = {DEC, 1'b0};

   logic [NeedW-1:0] fome_q, fome_d;
   logic [NeedW-1:0] felicidade_q, felicidade_d;
   logic [NeedW-1:0] sono_q, sono_d;
   logic             upd;

   divisor_tick #(
      .TICK_W (TICK_W)
   ) u_divisor_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Candidate need values for this tick, selected by the sampled activity
   always_comb begin
      fome_d       = fome_q;
      felicidade_d = felicidade_q;
      sono_d       = sono_q;
      case (estado)
         EstIntro: begin
            fome_d       = VAL_INICIAL;
            felicidade_d = VAL_INICIAL;
            sono_d       = VAL_INICIAL;
         end
         EstIdle: begin
            fome_d       = sat_update(fome_q, DecX, 1'b1);
            felicidade_d = sat_update(felicidade_q, DecX, 1'b1);
            sono_d       = sat_update(sono_q, DecX, 1'b1);
         end
         EstComendo: begin
            fome_d       = sat_update(fome_q, IncX, 1'b0);
            felicidade_d = sat_update(felicidade_q, DecX, 1'b1);
            sono_d       = sat_update(sono_q, DecX, 1'b1);
         end
         EstDormindo: begin
            sono_d       = sat_update(sono_q, IncX, 1'b0);
            fome_d       = sat_update(fome_q, DecX, 1'b1);
            felicidade_d = sat_update(felicidade_q, DecX, 1'b1);
         end
         EstDandoAula: begin
            felicidade_d = sat_update(felicidade_q, IncX, 1'b0);
            fome_d       = sat_update(fome_q, Dec2X, 1'b1);
            sono_d       = sat_update(sono_q, Dec2X, 1'b1);
         end
         // EstMorto and any unlisted or multi-hot code: hold
         default: ;
      endcase
   end

`ifdef NECESSIDADES_MORTE_EN
   logic morto_q, morto_d;

   assign upd = tick & ~morto_q;

   // Death latches when an applied update leaves any need empty
   always_comb begin
      morto_d = morto_q;
      if (upd && (fome_d == '0 || felicidade_d == '0 || sono_d == '0)) morto_d = 1'b1;
   end

   // Sticky death flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) morto_q <= 1'b0;
      else     morto_q <= morto_d;
   end

   assign morto = morto_q;
`else
   assign upd   = tick;
   assign morto = 1'b0;
`endif

   // Need registers advance only on enabled tick edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fome_q       <= VAL_INICIAL;
         felicidade_q <= VAL_INICIAL;
         sono_q       <= VAL_INICIAL;
      end else if (upd) begin
         fome_q       <= fome_d;
         felicidade_q <= felicidade_d;
         sono_q       <= sono_d;
      end
   end

   assign fome       = fome_q;
   assign felicidade = felicidade_q;
   assign sono       = sono_q;

endmodule

// File: tb/tb_controlador_necessidades.sv
// Bench for controlador_necessidades with TICK_W=4 (tick every 16 clocks).
// Reference model keeps the needs as plain integers clamped to [0,255].
module tb_controlador_necessidades;
   import controlador_necessidades_pkg::*;

   localparam int PER = 16;
`ifdef NECESSIDADES_MORTE_EN
   localparam bit DEATH = 1'b1;
`else
   localparam bit DEATH = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] estado;
   logic [7:0] fome, felicidade, sono;
   logic       morto, tick;

   int checks = 0;
   int errors = 0;
   int k;              // clock edges since reset release
   int mf, mh, ms;     // model needs
   bit mm;             // model death flag

   always #5 clk = ~clk;

   controlador_necessidades #(
      .TICK_W (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .estado     (estado),
      .fome       (fome),
      .felicidade (felicidade),
      .sono       (sono),
      .morto      (morto),
      .tick       (tick)
   );

   function automatic int clamp(input int x);
      if (x < 0) return 0;
      if (x > 255) return 255;
      return x;
   endfunction

   task automatic model_update(input logic [4:0] e);
      if (mm) return;
      case (e)
         5'b00000: begin mf = 128; mh = 128; ms = 128; end
         5'b00001: begin mf -= 1; mh -= 1; ms -= 1; end
         5'b00100: begin mf += 8; mh -= 1; ms -= 1; end
         5'b00010: begin ms += 8; mf -= 1; mh -= 1; end
         5'b01000: begin mh += 8; mf -= 2; ms -= 2; end
         default: ;
      endcase
      mf = clamp(mf); mh = clamp(mh); ms = clamp(ms);
      if (DEATH && (mf == 0 || mh == 0 || ms == 0)) mm = 1'b1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, got, exp, k);
      end
   endtask

   task automatic check_all();
      chk("fome", {24'd0, fome}, mf);
      chk("felicidade", {24'd0, felicidade}, mh);
      chk("sono", {24'd0, sono}, ms);
      chk("morto", {31'd0, morto}, {31'd0, mm});
      chk("tick", {31'd0, tick}, {31'd0, (k % PER) == PER - 1});
   endtask

   task automatic model_reset();
      mf = 128; mh = 128; ms = 128; mm = 1'b0; k = 0;
   endtask

   // One clock: drive estado, advance, update model on tick edges, check
   task automatic step(input logic [4:0] e);
      estado = e;
      @(posedge clk);
      k++;
      if (k % PER == 0) model_update(e);
      #1;
      check_all();
   endtask

   // Run n tick edges with e on each tick edge; optionally scramble estado between
   task automatic run_ticks(input logic [4:0] e, input int n, input bit toggle);
      int done = 0;
      while (done < n) begin
         if (((k + 1) % PER == 0) || !toggle) step(e);
         else step(5'($urandom));
         if (k % PER == 0) done++;
      end
   endtask

   // Asynchronous reset asserted mid-cycle, checked before any clock edge
   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [4:0] codes [8];
      int guard;
      codes[0] = EstIntro;   codes[1] = EstIdle;      codes[2] = EstDormindo;
      codes[3] = EstComendo; codes[4] = EstDandoAula; codes[5] = EstMorto;
      codes[6] = 5'b00110;   codes[7] = 5'b00000;

      rst    = 1'b1;
      estado = EstIdle;
      #3;
      model_reset();
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // Three IDLE ticks: 128 -> 125
      run_ticks(EstIdle, 3, 1'b0);
      chk("idle3_fome", {24'd0, fome}, 125);
      chk("idle3_sono", {24'd0, sono}, 125);

      // Feeding until fome saturates
      run_ticks(EstComendo, 16, 1'b1);
      chk("comendo16_fome", {24'd0, fome}, 253);
      run_ticks(EstComendo, 1, 1'b1);
      chk("comendo_sat_fome", {24'd0, fome}, 255);
      chk("comendo_sat_felicidade", {24'd0, felicidade}, 108);

      // Teaching until sono empties while felicidade sits at 255
      guard = 0;
      while (sono != 8'd0 && guard < 80) begin
         run_ticks(EstDandoAula, 1, 1'b1);
         guard++;
      end
      chk("aula_sono_zero", {24'd0, sono}, 0);
      chk("aula_fome", {24'd0, fome}, 147);
      chk("aula_felicidade_sat", {24'd0, felicidade}, 255);
      chk("aula_morto", {31'd0, morto}, {31'd0, DEATH});

      // Feeding after death: frozen with the flag, otherwise keeps running
      run_ticks(EstComendo, 1, 1'b1);
      chk("post_death_fome", {24'd0, fome}, DEATH ? 147 : 155);
      run_ticks(EstIdle, 2, 1'b1);
      chk("post_death_sono", {24'd0, sono}, 0);
      chk("post_death_morto", {31'd0, morto}, {31'd0, DEATH});

      // Reset 5 clocks before a tick
      while (k % PER != 11) step(EstIdle);
      do_reset();
      chk("rst_fome", {24'd0, fome}, 128);
      repeat (14) step(EstIdle);
      chk("rst_no_early_tick", {31'd0, tick}, 0);
      step(EstIdle);
      chk("rst_first_tick", {31'd0, tick}, 1);

      // Hold codes on tick edges with scrambled estado in between
      run_ticks(EstIdle, 1, 1'b1);
      chk("pre_hold_fome", {24'd0, fome}, 127);
      run_ticks(EstMorto, 1, 1'b1);
      chk("morto_hold_fome", {24'd0, fome}, 127);
      run_ticks(5'b00110, 1, 1'b1);
      chk("invalid_hold_sono", {24'd0, sono}, 127);
      run_ticks(EstIntro, 1, 1'b1);
      chk("intro_reload", {24'd0, felicidade}, 128);

      // Randomized activity sequence
      for (int i = 0; i < 60; i++) begin
         logic [4:0] e;
         e = codes[$urandom_range(0, 7)];
         if (e == 5'b00000 && $urandom_range(0, 1) == 1) e = 5'($urandom);
         run_ticks(e, 1, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/controlador_necessidades.md
# controlador_necessidades

Needs-update engine for the pet: consumes the 5-bit `estado` one-hot code produced by the state controller and maintains the three 8-bit need levels (`fome`, `felicidade`, `sono`) that the state controller reads back. It closes the loop between buttons and needs. Values rise or decay at a slow, prescaled rate according to the current activity. An optional sticky death flag fires when any need reaches zero.

## Interface
Parameters:
- `TICK_W`, 22: prescaler width; one update tick every 2^TICK_W clocks.
- `VAL_INICIAL`, 8'd128: reset and INTRO value of all three needs.
- `INC`, 8'd8: per-tick increase for the need being served.
- `DEC`, 8'd1: per-tick base decay.

Ports:
- `clk`  in  1  system clock; the design uses a single clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `estado`  in  5  current state code: INTRO=00000, IDLE=00001, DORMINDO=00010, COMENDO=00100, DANDO_AULA=01000, MORTO=10000.
- `fome`  out  8  hunger level; 0 means starving.
- `felicidade`  out  8  happiness level.
- `sono`  out  8  rest level.
- `morto`  out  1  sticky death flag.
- `tick`  out  1  one-cycle pulse marking each update; for debug and verification.

## Operation
- Prescaler `cnt[TICK_W-1:0]` increments every clock. `tick` is 1 while `cnt` is all-ones.
- Needs change only on a clock edge where `tick`=1 and `morto`=0. At all other times they hold.
- Per-tick update, selected by `estado` sampled on the tick edge:
  - INTRO: load `VAL_INICIAL` into all three needs.
  - IDLE: all three decrease by DEC.
  - COMENDO: `fome`+INC, `felicidade`−DEC, `sono`−DEC.
  - DORMINDO: `sono`+INC, `fome`−DEC, `felicidade`−DEC.
  - DANDO_AULA: `felicidade`+INC, `fome`−2·DEC, `sono`−2·DEC.
  - MORTO, or any non-listed code (including multi-hot): hold.
- Arithmetic is performed at 9 bits. Results saturate at 0 and 255 and never wrap.
- `morto` is set on the tick edge whose update result leaves any need at 0. It stays set until `rst`. While `morto`=1, all needs freeze.

## Timing
- Reset values: `fome`=`felicidade`=`sono`=VAL_INICIAL; `morto`=0; `cnt`=0; `tick`=0.
- The first tick occurs 2^TICK_W−1 clocks after reset deassertion. Subsequent ticks follow every 2^TICK_W clocks.
- Latency: needs and `morto` update on the same edge on which `tick`=1 is sampled. Both are registered outputs, so the new values are visible the following cycle.
- `estado` is sampled only on tick edges. Changes between ticks have no effect.
- A need that reaches 0 in the same update in which another need saturates at 255 still sets `morto`.
- Asserting `rst` mid-operation immediately restores all reset values, regardless of the clock.

## Configuration
- `NECESSIDADES_MORTE_EN` defined: `morto` behaves as described above, and the needs freeze once it is set.
- Undefined: `morto` is tied to 0 and the freeze logic is not generated. Needs continue to saturate at 0 indefinitely.

## Structure
- Shared package holds:
  - the six `estado` localparams, which are shared with the state controller;
  - a need-width constant of 8;
  - a saturating add/sub function.
- One sub-module: `divisor_tick`, which contains the parameterised `TICK_W` free-running counter and produces the `tick` pulse.

## Test plan
All scenarios run with TICK_W=4, so a tick occurs every 16 clocks.
- Reset then hold `estado`=IDLE for 3 ticks -> all three needs = 125; `morto`=0.
- `estado`=COMENDO with `fome`=250, one tick -> `fome`=255 (saturated); `felicidade` and `sono` each decrease by 1.
- `estado`=DANDO_AULA with `fome`=2, one tick -> `fome`=0 and `morto`=1. On the next tick, with `estado`=COMENDO, all needs stay unchanged (with the macro defined).
- Same stimulus with the macro undefined -> `morto` stays 0, `fome` stays at 0, and COMENDO raises `fome` to 8.
- Toggle `estado` between ticks, then set it to MORTO exactly on a tick edge -> no change. Also drive the invalid code 00110 on a tick edge -> hold.
- Assert `rst` 5 clocks before a tick -> needs = 128 immediately; the next tick occurs 15 clocks after release.
